// File: rtl/lenet_pkg.sv
// Shared LeNet constants: data width, tensor dimensions, phase lengths and loader states.
package lenet_pkg;

    localparam int BITWIDTH = 32;
    localparam int NKERN    = 2;
    localparam int NCHAN    = 2;
    localparam int KSIZE    = 5;
    localparam int FSIZE    = 14;
    localparam int KLEN     = NKERN * NCHAN * KSIZE * KSIZE;
    localparam int FLEN     = NCHAN * FSIZE * FSIZE;

    typedef enum logic [1:0] {
        LOAD_K,
        LOAD_F,
        HOLD
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Nested raster index counter: digit 0 varies fastest, each digit wraps at its own limit.
module raster_counter #(
    parameter int NDIM = 4,
    parameter int W    = 4,
    parameter logic [NDIM-1:0][W-1:0] LIMS = '1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [NDIM-1:0][W-1:0] idx,
    output logic                 wrap
);

    logic [NDIM-1:0][W-1:0] idx_nxt;
    logic                   carry;

    // Ripple the increment from the fastest digit outward; clear overrides everything.
    always_comb begin
        idx_nxt = idx;
        carry   = inc;
        wrap    = 1'b1;
        for (int d = 0; d < NDIM; d++) begin
            wrap = wrap & (idx[d] == LIMS[d]);
            if (carry) begin
                if (idx[d] == LIMS[d]) begin
                    idx_nxt[d] = '0;
                end else begin
                    idx_nxt[d] = idx[d] + W'(1);
                    carry      = 1'b0;
                end
            end
        end
        if (clr) begin
            idx_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else begin
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/fmap_loader.sv
// Streams a kernel set and a feature map into flat register arrays, then holds them for a consumer.
module fmap_loader
    import lenet_pkg::*;
#(
    parameter int BITWIDTH = lenet_pkg::BITWIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [BITWIDTH-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic signed [BITWIDTH-1:0] kernel_out [NKERN-1:0][NCHAN-1:0][KSIZE-1:0][KSIZE-1:0],
    output logic signed [BITWIDTH-1:0] fmap_out [NCHAN-1:0][FSIZE-1:0][FSIZE-1:0],
    output logic                       out_valid,
    input  logic                       out_consume,
    input  logic                       kernel_reload,
    output logic                       err_len
);

    localparam int CW = 4;

    state_t state, state_nxt;
    logic   fire;
    logic   k_inc, k_clr, k_we, k_wrap;
    logic   f_inc, f_clr, f_we, f_wrap;
    logic   err_nxt;
    logic [3:0][CW-1:0] k_idx;
    logic [2:0][CW-1:0] f_idx;

    raster_counter #(
        .NDIM (4),
        .W    (CW),
        .LIMS ({CW'(NKERN-1), CW'(NCHAN-1), CW'(KSIZE-1), CW'(KSIZE-1)})
    ) u_kcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (k_inc),
        .clr   (k_clr),
        .idx   (k_idx),
        .wrap  (k_wrap)
    );

    raster_counter #(
        .NDIM (3),
        .W    (CW),
        .LIMS ({CW'(NCHAN-1), CW'(FSIZE-1), CW'(FSIZE-1)})
    ) u_fcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (f_inc),
        .clr   (f_clr),
        .idx   (f_idx),
        .wrap  (f_wrap)
    );

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign fire      = in_valid && in_ready;

    // An early in_last drops the word and restarts the phase; a missing in_last on the final word only flags it.
    always_comb begin
        state_nxt = state;
        k_inc     = 1'b0;
        k_clr     = 1'b0;
        k_we      = 1'b0;
        f_inc     = 1'b0;
        f_clr     = 1'b0;
        f_we      = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            LOAD_K: begin
                if (fire) begin
                    if (in_last && !k_wrap) begin
                        k_clr   = 1'b1;
                        err_nxt = 1'b1;
                    end else if (k_wrap) begin
                        k_we      = 1'b1;
                        k_clr     = 1'b1;
                        err_nxt   = !in_last;
                        state_nxt = LOAD_F;
                    end else begin
                        k_we  = 1'b1;
                        k_inc = 1'b1;
                    end
                end
            end
            LOAD_F: begin
                if (fire) begin
                    if (in_last && !f_wrap) begin
                        f_clr   = 1'b1;
                        err_nxt = 1'b1;
                    end else if (f_wrap) begin
                        f_we      = 1'b1;
                        f_clr     = 1'b1;
                        err_nxt   = !in_last;
                        state_nxt = HOLD;
                    end else begin
                        f_we  = 1'b1;
                        f_inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_consume) begin
                    state_nxt = kernel_reload ? LOAD_K : LOAD_F;
                end
            end
            default: state_nxt = LOAD_K;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD_K;
            err_len <= 1'b0;
        end else begin
            state   <= state_nxt;
            err_len <= err_nxt;
        end
    end

    // Each array entry decodes its own raster address, so words land in place as they arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NKERN; k++)
                for (int c = 0; c < NCHAN; c++)
                    for (int r = 0; r < KSIZE; r++)
                        for (int x = 0; x < KSIZE; x++)
                            kernel_out[k][c][r][x] <= '0;
            for (int c = 0; c < NCHAN; c++)
                for (int r = 0; r < FSIZE; r++)
                    for (int x = 0; x < FSIZE; x++)
                        fmap_out[c][r][x] <= '0;
        end else begin
            for (int k = 0; k < NKERN; k++)
                for (int c = 0; c < NCHAN; c++)
                    for (int r = 0; r < KSIZE; r++)
                        for (int x = 0; x < KSIZE; x++)
                            if (k_we && k_idx == {CW'(k), CW'(c), CW'(r), CW'(x)})
                                kernel_out[k][c][r][x] <= in_data;
            for (int c = 0; c < NCHAN; c++)
                for (int r = 0; r < FSIZE; r++)
                    for (int x = 0; x < FSIZE; x++)
                        if (f_we && f_idx == {CW'(c), CW'(r), CW'(x)})
                            fmap_out[c][r][x] <= in_data;
        end
    end

endmodule

// File: tb/tb_fmap_loader.sv
// Directed bench for fmap_loader: full load, bubbles, consume paths, length errors and mid-load reset.
module tb_fmap_loader;

    logic               clk;
    logic               rst_n;
    logic signed [31:0] in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic signed [31:0] kernel_out [1:0][1:0][4:0][4:0];
    logic signed [31:0] fmap_out [1:0][13:0][13:0];
    logic               out_valid;
    logic               out_consume;
    logic               kernel_reload;
    logic               err_len;

    int total = 0;
    int bad   = 0;

    fmap_loader #(.BITWIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .kernel_out    (kernel_out),
        .fmap_out      (fmap_out),
        .out_valid     (out_valid),
        .out_consume   (out_consume),
        .kernel_reload (kernel_reload),
        .err_len       (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    initial begin
        int n;
        int cyc;
        logic v;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_consume = 1'b0; kernel_reload = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_err_len", 32'(err_len), 0);
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_kernel", kernel_out[0][0][0][0], 0);
        checkOutput("rst_fmap", fmap_out[1][13][13], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean kernel + feature map load
        for (int i = 0; i < 100; i++) applyStimulus(32'(i), i == 99);
        for (int i = 0; i < 392; i++) begin
            if (i == 391) checkOutput("ov_before_last", 32'(out_valid), 0);
            applyStimulus(32'(1000 + i), i == 391);
        end
        checkOutput("ov_after_last", 32'(out_valid), 1);
        checkOutput("err_clean", 32'(err_len), 0);
        checkOutput("k_1144", kernel_out[1][1][4][4], 99);
        checkOutput("k_0123", kernel_out[0][1][2][3], 38);
        checkOutput("f_11313", fmap_out[1][13][13], 1391);
        checkOutput("f_000", fmap_out[0][0][0], 1000);
        checkOutput("f_105", fmap_out[1][0][5], 1201);

        // HOLD refuses offered words and keeps everything stable
        in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", 32'(in_ready), 0);
            checkOutput("hold_out_valid", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        checkOutput("hold_f_000", fmap_out[0][0][0], 1000);

        // Consume without reload, then a bubbly fmap stream of negative words
        out_consume = 1'b1; kernel_reload = 1'b0;
        @(negedge clk);
        out_consume = 1'b0;
        checkOutput("consume_ov_low", 32'(out_valid), 0);
        checkOutput("consume_ready", 32'(in_ready), 1);
        n = 0; cyc = 0;
        while (n < 392 && cyc < 3000) begin
            v = 1'($urandom_range(0, 1));
            out_consume   = (cyc == 50);
            kernel_reload = (cyc == 50);
            in_valid = v;
            in_data  = -(n + 1);
            in_last  = (n == 391);
            @(negedge clk);
            if (v) n++;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_consume = 1'b0; kernel_reload = 1'b0;
        checkOutput("bubble_done", 32'(n), 392);
        checkOutput("bubble_ov", 32'(out_valid), 1);
        checkOutput("bubble_f_11313", fmap_out[1][13][13], -392);
        checkOutput("bubble_f_073", fmap_out[0][7][3], -102);
        checkOutput("kept_k_1144", kernel_out[1][1][4][4], 99);
        checkOutput("kept_k_0123", kernel_out[0][1][2][3], 38);

        // Reload kernel with an early in_last on word 50
        out_consume = 1'b1; kernel_reload = 1'b1;
        @(negedge clk);
        out_consume = 1'b0; kernel_reload = 1'b0;
        checkOutput("reload_ov_low", 32'(out_valid), 0);
        for (int i = 0; i < 50; i++) applyStimulus(32'(500 + i), 1'b0);
        applyStimulus(32'd7777, 1'b1);
        checkOutput("early_err_hi", 32'(err_len), 1);
        applyStimulus(32'd4242, 1'b0);
        checkOutput("early_err_lo", 32'(err_len), 0);
        checkOutput("early_k_idx0", kernel_out[0][0][0][0], 4242);
        checkOutput("early_k_idx1_old", kernel_out[0][0][0][1], 501);
        for (int i = 1; i < 100; i++) applyStimulus(32'(300 + i), i == 99);
        checkOutput("early_k_idx1_new", kernel_out[0][0][0][1], 301);
        checkOutput("early_k_1144", kernel_out[1][1][4][4], 399);

        // Feature map with in_last missing on its final word
        for (int i = 0; i < 392; i++) applyStimulus(32'(5000 + i), 1'b0);
        in_valid = 1'b0;
        checkOutput("nolast_err_hi", 32'(err_len), 1);
        checkOutput("nolast_ov", 32'(out_valid), 1);
        checkOutput("nolast_f_11313", fmap_out[1][13][13], 5391);
        @(negedge clk);
        checkOutput("nolast_err_lo", 32'(err_len), 0);

        // Reset in the middle of a feature-map load
        out_consume = 1'b1; kernel_reload = 1'b0;
        @(negedge clk);
        out_consume = 1'b0;
        for (int i = 0; i < 200; i++) applyStimulus(32'(6000 + i), 1'b0);
        in_valid = 1'b0;
        checkOutput("mid_f_103", fmap_out[1][0][3], 6199);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_f_103", fmap_out[1][0][3], 0);
        checkOutput("midrst_f_000", fmap_out[0][0][0], 0);
        checkOutput("midrst_k_1144", kernel_out[1][1][4][4], 0);
        checkOutput("midrst_ov", 32'(out_valid), 0);
        checkOutput("midrst_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(in_ready), 1);
        applyStimulus(32'd8888, 1'b0);
        in_valid = 1'b0;
        checkOutput("post_rst_k0", kernel_out[0][0][0][0], 8888);
        checkOutput("post_rst_f0", fmap_out[0][0][0], 0);
        checkOutput("post_rst_ov", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
